// File: rtl/bcd_conv_arbiter.sv
//==============================================================================
// Module   : bcd_conv_arbiter
// Function : round-robin sequencer sharing one 16-bit binary-to-BCD converter.
//            Optional watchdog + drain when BCD_ARB_TIMEOUT_EN is defined.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bcd_conv_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [15:0]                   rsp_bcd,
    output logic                          rsp_ovf,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         conv_data,
    output logic                          conv_start,
    input  logic                          conv_done,
    input  logic [15:0]                   conv_bcd
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_RESP  = 3'd5
`ifdef BCD_ARB_TIMEOUT_EN
        ,S_DRAIN = 3'd6
`endif
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 14 || TIMEOUT < 1) begin : g_bad_param
            $error("bcd_conv_arbiter: unsupported NUM_REQ/DATA_WIDTH/TIMEOUT");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_grant;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic                    r_ovf;
    logic                    w_any;
    logic [IDX_W-1:0]        w_grant;
    logic [SUM_W-1:0]        w_sum;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    // First set request at or after the round-robin pointer, wrapping.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            if (!w_any && req[w_sum[IDX_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_wd_expired;

    assign w_wd_expired = (r_wd_cnt == CNT_W'(TIMEOUT));

    // Counts cycles spent in WAIT or DRAIN; cleared everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (conv_done) begin
                    w_next = S_CAPT;
                end
`ifdef BCD_ARB_TIMEOUT_EN
                else if (w_wd_expired) begin
                    w_next = S_RESP;
                end
`endif
            end
            S_CAPT:  w_next = S_RESP;
`ifdef BCD_ARB_TIMEOUT_EN
            // A timed-out conversion may still complete; absorb its done.
            S_RESP:  w_next = rsp_err ? S_DRAIN : S_IDLE;
            S_DRAIN: if (conv_done || w_wd_expired) w_next = S_IDLE;
`else
            S_RESP:  w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_ovf     <= 1'b0;
            conv_data <= '0;
            rsp_bcd   <= '0;
            rsp_ovf   <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                // Operand is latched at grant so it is stable during LOAD.
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_grant;
                        conv_data <= w_sel_data;
                    end
                end
                S_LOAD: r_ovf <= (conv_data > DATA_WIDTH'(9999));
                S_CAPT: begin
                    rsp_bcd <= r_ovf ? 16'h9999 : conv_bcd;
                    rsp_ovf <= r_ovf;
`ifdef BCD_ARB_TIMEOUT_EN
                    rsp_err <= 1'b0;
`endif
                end
                S_RESP: begin
                    r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
                end
`ifdef BCD_ARB_TIMEOUT_EN
                S_WAIT: begin
                    if (!conv_done && w_wd_expired) begin
                        rsp_bcd <= '0;
                        rsp_ovf <= 1'b0;
                        rsp_err <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign conv_start = (r_state == S_START);

    always_comb begin
        ack = '0;
        if (r_state == S_RESP) begin
            ack[r_grant] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
//==============================================================================
// Module   : tb_bcd_conv_arbiter
// Function : directed + random bench for bcd_conv_arbiter with a converter model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bcd_conv_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [15:0]       rsp_bcd;
    logic              rsp_ovf;
    logic              rsp_err;
    logic              busy;
    logic [DW-1:0]     conv_data;
    logic              conv_start;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    logic              cv_done;
    logic              inj_done;
    int                cv_cnt;
    logic [DW-1:0]     cv_op;
    int                cv_lat;
    bit                cv_hang;

    logic [DW-1:0]     ops [N];
    int                n_vec;
    int                n_fail;
    int                m_ptr;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ops[i];
    end

    assign conv_done = cv_done | inj_done;

    bcd_conv_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .rsp_bcd    (rsp_bcd),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .conv_data  (conv_data),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    function automatic logic [15:0] to_bcd(input int v);
        int t;
        t = v % 10000;
        return 16'((t / 1000) * 4096 + ((t / 100) % 10) * 256 + ((t / 10) % 10) * 16 + (t % 10));
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Converter model: done pulses cv_lat cycles after start, digits follow a cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_done  <= 1'b0;
            cv_cnt   <= 0;
            cv_op    <= '0;
            conv_bcd <= '0;
        end else begin
            cv_done <= 1'b0;
            if (cv_done) conv_bcd <= to_bcd(int'(cv_op));
            if (conv_start) begin
                cv_op  <= conv_data;
                cv_cnt <= cv_hang ? 0 : cv_lat - 1;
                if (!cv_hang && cv_lat == 1) cv_done <= 1'b1;
            end else if (cv_cnt > 0) begin
                cv_cnt <= cv_cnt - 1;
                if (cv_cnt == 1) cv_done <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One granted transaction: start, operand, ack latency, result, pulse width.
    task automatic do_txn(input int g, input int lat, input bit e_err, input bit drop);
        int          waited;
        bit          early;
        logic [15:0] e_bcd;
        logic        e_ovf;
        waited = 0;
        early  = 1'b0;
        while (!conv_start && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("start_seen", 32'(conv_start), 32'd1);
        if (!conv_start) return;
        check("conv_data", 32'(conv_data), 32'(ops[g]));
        e_ovf = !e_err && (ops[g] > 16'd9999);
        e_bcd = e_err ? 16'h0000 : (e_ovf ? 16'h9999 : to_bcd(int'(ops[g])));
        for (int k = 0; k < lat + 1; k++) begin
            @(posedge clk); #1;
            if (ack !== '0) early = 1'b1;
        end
        check("ack_early", 32'(early), 32'd0);
        @(posedge clk); #1;
        check("ack", 32'(ack), 32'(1 << g));
        check("rsp_bcd", 32'(rsp_bcd), 32'(e_bcd));
        check("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        m_ptr = (g + 1) % N;
        if (drop) req[g] = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack), 32'd0);
        check("busy_after", 32'(busy), 32'(e_err));
    endtask

    initial begin
        logic [N-1:0] nb;
        int           g;
        rst_n    = 1'b0;
        req      = '0;
        inj_done = 1'b0;
        cv_lat   = 2;
        cv_hang  = 1'b0;
        n_vec    = 0;
        n_fail   = 0;
        m_ptr    = 0;
        for (int i = 0; i < N; i++) ops[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_bcd", 32'(rsp_bcd), 32'd0);
        check("rst_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(conv_start), 32'd0);
        check("rst_cdata", 32'(conv_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four held: strict rotation 0,1,2,3,0.
        ops = '{16'd5, 16'd60, 16'd700, 16'd8000};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cv_lat = 1 + i;
            do_txn(i % N, cv_lat, 1'b0, 1'b0);
        end
        req = '0;

        // Single request: LOAD at +1, START at +2.
        ops[1] = 16'd1234;
        req    = 4'b0010;
        cv_lat = 3;
        @(posedge clk); #1;
        check("load_no_start", 32'(conv_start), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("start_at_2", 32'(conv_start), 32'd1);
        do_txn(1, 3, 1'b0, 1'b1);

        // Pointer wrap after serving client 2.
        ops[2] = 16'd42;
        req    = 4'b0100;
        cv_lat = 2;
        do_txn(2, 2, 1'b0, 1'b1);
        ops[0] = 16'd9;
        ops[2] = 16'd31;
        req    = 4'b0101;
        check("rr_model", 32'(pick(req, m_ptr)), 32'd0);
        do_txn(0, 2, 1'b0, 1'b1);
        do_txn(2, 2, 1'b0, 1'b1);

        // Overflow then zero.
        ops[1] = 16'd12345;
        req    = 4'b0010;
        do_txn(1, 2, 1'b0, 1'b1);
        ops[1] = 16'd0;
        req    = 4'b0010;
        do_txn(1, 2, 1'b0, 1'b1);

        // Random arrivals against the round-robin reference.
        for (int it = 0; it < 40; it++) begin
            nb = N'($urandom_range(0, (1 << N) - 1)) & ~req;
            for (int i = 0; i < N; i++) begin
                if (nb[i]) ops[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(10000, 65535))
                                                                 : 16'($urandom_range(0, 9999));
            end
            req = req | nb;
            if (req == '0) begin
                ops[it % N] = 16'($urandom_range(0, 9999));
                req[it % N] = 1'b1;
            end
            g      = pick(req, m_ptr);
            cv_lat = int'($urandom_range(1, 5));
            do_txn(g, cv_lat, 1'b0, 1'b1);
        end
        req = '0;

        // Asynchronous reset while waiting on the converter.
        ops[2] = 16'd4321;
        req    = 4'b0100;
        cv_lat = 10;
        for (int k = 0; k < 10 && !conv_start; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_start", 32'(conv_start), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cdata", 32'(conv_data), 32'd0);
        check("arst_bcd", 32'(rsp_bcd), 32'd0);
        check("arst_ovf", 32'(rsp_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_ptr  = 0;
        cv_lat = 2;
        do_txn(2, 2, 1'b0, 1'b1);
        req = '0;

`ifdef BCD_ARB_TIMEOUT_EN
        // Converter never answers: error response, then drain absorbs a late done.
        ops[3]  = 16'd77;
        req     = 4'b1000;
        cv_hang = 1'b1;
        do_txn(3, 64, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("drain_busy", 32'(busy), 32'd1);
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        check("drain_exit", 32'(busy), 32'd0);
        cv_hang = 1'b0;
        ops[0]  = 16'd2468;
        req     = 4'b0001;
        cv_lat  = 3;
        do_txn(0, 3, 1'b0, 1'b1);
        req = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
